// File: rtl/csum_pkg.sv
// Shared helpers for the 16-bit ones'-complement stream checksum engine.
package csum_pkg;

    function automatic int unsigned csum_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Per-beat lane sum plus the seed never exceeds (DATA_W/16 + 1) * 0xFFFF.
    function automatic int unsigned csum_sum_w(input int unsigned data_w);
        return 16 + $clog2(data_w / 16) + 1;
    endfunction

    // End-around carry reduction to 16 bits; two passes are always enough.
    function automatic logic [15:0] fold16(input logic [31:0] x);
        logic [16:0] s;
        s = {1'b0, x[15:0]} + {1'b0, x[31:16]};
        s = {1'b0, s[15:0]} + {16'b0, s[16]};
        return s[15:0];
    endfunction

    function automatic logic [15:0] lane_place(input logic [7:0] b, input logic odd);
        return odd ? {8'h00, b} : {b, 8'h00};
    endfunction

endpackage

// File: rtl/csum16_stream_engine_lane_adder.sv
// Combinational mask, word placement and reduction of one tapped beat.
module csum_lane_adder
    import csum_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned START_W = 16,
    parameter int unsigned SUM_W   = 19,
    parameter int unsigned CNT_W   = 4
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] keep,
    input  logic [START_W-1:0]  beat_cnt,
    input  logic [START_W-1:0]  start,
    output logic [SUM_W-1:0]    sum,
    output logic [CNT_W-1:0]    cnt
);
    localparam int unsigned BYTES = csum_bytes(DATA_W);
    localparam int unsigned POS_W = START_W + $clog2(BYTES) + 1;

    logic [BYTES-1:0] en;
    logic [15:0]      placed [BYTES];

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic [POS_W-1:0] pos;
        assign pos       = POS_W'(beat_cnt) * POS_W'(BYTES) + POS_W'(i);
        assign en[i]     = keep[i] && (pos >= POS_W'(start));
        // Beats are an even byte count wide, so word parity is lane parity xor start parity.
        assign placed[i] = en[i] ? lane_place(data[8*i +: 8], 1'(i % 2) ^ start[0]) : 16'h0000;
    end

    always_comb begin
        sum = '0;
        cnt = '0;
        for (int i = 0; i < BYTES; i++) begin
            sum = sum + SUM_W'(placed[i]);
            cnt = cnt + CNT_W'(en[i]);
        end
    end

endmodule

// File: rtl/csum16_stream_engine.sv
// Passive AXI-Stream tap computing an RFC 1071 checksum from a per-packet byte offset,
// with a 3-cycle pipeline and a held valid/ready result port.
module csum16_stream_engine
    import csum_pkg::*;
#(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned START_W      = 16,
    parameter int unsigned LEN_W        = 16,
    parameter bit          ZERO_TO_FFFF = 1'b0
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                s_valid,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    input  logic [START_W-1:0]  cfg_start,
    input  logic [15:0]         cfg_seed,
    output logic                csum_valid,
    input  logic                csum_ready,
    output logic [15:0]         csum_data,
    output logic [LEN_W-1:0]    csum_len,
    output logic                err_overrun
);
    localparam int unsigned BYTES  = csum_bytes(DATA_W);
    localparam int unsigned SUM_W  = csum_sum_w(DATA_W);
    localparam int unsigned CNT_W  = $clog2(BYTES + 1);
    localparam int unsigned ACC_W  = 17;
    localparam int unsigned ACCX_W = SUM_W + 1;
    localparam int unsigned LENX_W = LEN_W + 1;

    logic beat;
    assign beat = s_valid && s_ready;

    // Packet tracking
    logic               sop_q;
    logic [START_W-1:0] start_q, beat_cnt_q;
    logic [START_W-1:0] cur_start, cur_beat;

    assign cur_start = sop_q ? cfg_start : start_q;
    assign cur_beat  = sop_q ? '0 : beat_cnt_q;

    logic [SUM_W-1:0] lane_sum, seed_add, s1_sum_d;
    logic [CNT_W-1:0] lane_cnt;

    csum_lane_adder #(
        .DATA_W  (DATA_W),
        .START_W (START_W),
        .SUM_W   (SUM_W),
        .CNT_W   (CNT_W)
    ) u_lane_adder (
        .data     (s_data),
        .keep     (s_keep),
        .beat_cnt (cur_beat),
        .start    (cur_start),
        .sum      (lane_sum),
        .cnt      (lane_cnt)
    );

    assign seed_add = sop_q ? SUM_W'(cfg_seed) : '0;
    assign s1_sum_d = lane_sum + seed_add;

    // Stage 1: per-beat sum token tagged with start/last markers
    logic             s1_valid_q, s1_sop_q, s1_last_q;
    logic [SUM_W-1:0] s1_sum_q;
    logic [CNT_W-1:0] s1_cnt_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            sop_q      <= 1'b1;
            start_q    <= '0;
            beat_cnt_q <= '0;
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sum_q   <= '0;
            s1_cnt_q   <= '0;
        end else begin
            s1_valid_q <= beat;
            if (beat) begin
                sop_q      <= s_last;
                start_q    <= cur_start;
                beat_cnt_q <= (&cur_beat) ? cur_beat : cur_beat + START_W'(1);
                s1_sop_q   <= sop_q;
                s1_last_q  <= s_last;
                s1_sum_q   <= s1_sum_d;
                s1_cnt_q   <= lane_cnt;
            end
        end
    end

    // Stage 2: accumulate with a single end-around carry pass
    logic [ACC_W-1:0]  acc_q, acc_base, acc_d;
    logic [ACCX_W-1:0] acc_x;
    logic [LEN_W-1:0]  len_q, len_base, len_d;
    logic [LENX_W-1:0] len_x;
    logic              s2_last_q;

    assign acc_base = s1_sop_q ? '0 : acc_q;
    assign acc_x    = ACCX_W'(acc_base) + ACCX_W'(s1_sum_q);
    assign acc_d    = ACC_W'(acc_x[15:0]) + ACC_W'(acc_x[ACCX_W-1:16]);

    assign len_base = s1_sop_q ? '0 : len_q;
    assign len_x    = LENX_W'(len_base) + LENX_W'(s1_cnt_q);
    assign len_d    = len_x[LEN_W] ? '1 : len_x[LEN_W-1:0];

    always_ff @(posedge clk) begin
        if (areset) begin
            acc_q     <= '0;
            len_q     <= '0;
            s2_last_q <= 1'b0;
        end else begin
            s2_last_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_q <= acc_d;
                len_q <= len_d;
            end
        end
    end

    // Final fold and result register
    logic [15:0] fold_r, res_inv, res_out;

    assign fold_r  = fold16(32'(acc_q));
    assign res_inv = ~fold_r;
    assign res_out = (ZERO_TO_FFFF && (res_inv == 16'h0000)) ? 16'hFFFF : res_inv;

    logic             csum_valid_q, err_overrun_q;
    logic [15:0]      csum_data_q;
    logic [LEN_W-1:0] csum_len_q;

    always_ff @(posedge clk) begin
        if (areset) begin
            csum_valid_q  <= 1'b0;
            csum_data_q   <= '0;
            csum_len_q    <= '0;
            err_overrun_q <= 1'b0;
        end else begin
            err_overrun_q <= s2_last_q && csum_valid_q && !csum_ready;
            if (s2_last_q && (!csum_valid_q || csum_ready)) begin
                csum_valid_q <= 1'b1;
                csum_data_q  <= res_out;
                csum_len_q   <= len_q;
            end else if (!s2_last_q && csum_valid_q && csum_ready) begin
                csum_valid_q <= 1'b0;
            end
        end
    end

    assign csum_valid  = csum_valid_q;
    assign csum_data   = csum_data_q;
    assign csum_len    = csum_len_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: doc/csum16_stream_engine.md
Name: csum16_stream_engine

Overview:
- Parametrised ones'-complement (RFC 1071) checksum engine that passively taps an AXI-Stream link; it never drives the ready signal.
- Sums bytes from a per-packet byte offset to the end of the packet and adds a per-packet 16-bit seed (pseudo-header partial sum).
- Returns the complemented 16-bit result and the summed byte count on a valid/ready result port.
- Replaces the fixed-offset, fixed-width checksum taps in the crypto/packet datapath; usable for IPv4 header, TCP and UDP checksums.

Parameters:
DATA_W, 64, tap data width in bits; multiple of 16, range 16..512
START_W, 16, width of the byte-offset config field
LEN_W, 16, width of the byte-count output
ZERO_TO_FFFF, 0, 1 = report a 0x0000 result as 0xFFFF (UDP rule)

Ports:
clk  in  1  clock
areset  in  1  synchronous reset, active-high
s_valid  in  1  tapped TVALID
s_ready  in  1  tapped TREADY (observed only)
s_data  in  DATA_W  tapped TDATA; byte lane 0 is the first byte on the wire
s_keep  in  DATA_W/8  tapped TKEEP
s_last  in  1  tapped TLAST
cfg_start  in  START_W  first byte offset summed; sampled on the first beat of each packet
cfg_seed  in  16  initial ones'-complement addend; sampled on the first beat of each packet
csum_valid  out  1  result available
csum_ready  in  1  result consumer ready
csum_data  out  16  complemented checksum
csum_len  out  LEN_W  number of bytes summed (saturates at all-ones)
err_overrun  out  1  one-cycle pulse when a result is dropped

Behaviour:
- Clock clk; reset areset, synchronous, active-high.
- Reset values: csum_valid=0, csum_data=0, csum_len=0, err_overrun=0. The internal accumulator, beat counter and length counter clear, and the start-of-packet flag sets to 1.
- A beat counts only when s_valid && s_ready. No other cycle changes state, except the result handshake.
- Start of packet: the first counted beat after reset, or the first after a beat with s_last=1. On that beat, latch cfg_start and cfg_seed; the beat counter begins at 0.
- Byte position of lane i = beat_cnt*(DATA_W/8) + i.
- A byte is summed iff s_keep[i]=1 and its position >= the latched start.
- Word alignment is relative to the start offset. A byte whose (position - start) is even goes in bits [15:8]; a byte whose (position - start) is odd goes in bits [7:0]. Because the beat is an even number of bytes wide, the parity is i XOR start[0].
- An unpaired trailing byte is padded with 0x00 in the low half.
- Non-contiguous s_keep bytes are masked individually, and each byte keeps its positional parity.
- Beat counter saturates; once positions exceed 2^START_W, all bytes are summed.
- Pipeline stage 1 (registered): the per-beat lane sum is reduced into 16+log2(DATA_W/16)+1 bits, and the per-beat summed-byte count is registered.
- Pipeline stage 2: acc <= fold(acc + stage1). The fold is an end-around carry, so acc stays in [0, 0xFFFF] plus carry bits. The seed is added at stage 1 of the first beat.
- On the s_last beat, stage 2 is followed by a final-fold cycle: r = fold16(acc), then csum_data = ~r. If ZERO_TO_FFFF=1 and ~r == 0x0000, output 0xFFFF instead.
- Latency: csum_valid rises exactly 3 cycles after the s_last handshake cycle.
- Back-to-back packets are supported at full rate. Per-packet pipeline tokens carry the start-of-packet and last markers, so packets never mix.
- Result port: csum_valid, csum_data and csum_len hold stable until csum_valid && csum_ready.
- Overrun: a new result completes while csum_valid=1 and csum_ready=0.
  - The new result is discarded and the old result is kept.
  - err_overrun pulses for 1 cycle.
- Simultaneous events: if a handshake and a new-result completion occur in the same cycle, the new result loads and csum_valid stays 1, with no error.
- Single-beat packet (start and last in the same beat) is legal.
- A packet whose summed bytes are all masked yields ~fold(seed), with csum_len=0.
- Reset mid-packet: the in-flight packet is abandoned with no result. The next counted beat is treated as a start of packet.
- Reset mid-result: the pending result is lost.

Decomposition:
- Package csum_pkg:
  - function fold16 (end-around carry reduce to 16 bits)
  - function lane_place (byte-to-word placement by parity)
  - localparams BYTES=DATA_W/8 and SUM_W
- Sub-module csum_lane_adder: combinational mask, place and reduce of one beat into SUM_W bits, registered by the parent as stage 1.
- The parent owns the counters, accumulator, final fold and result register.

Test Plan:
- IPv4 header 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7 sent in 3 beats (last keep=0x0F), start=0, seed=0 -> csum_data=0xB861, csum_len=20, csum_valid 3 cycles after last.
- Same header preceded by a 14-byte Ethernet header (5 beats), start=14 -> csum_data=0xB861, csum_len=20.
- Odd alignment: one beat AA 01 02 03, keep=0x0F, start=1 -> words 0x0102 and 0x0300 -> csum_data=0xFBFD, csum_len=3. Also start=0 with bytes 01 02 03, keep=0x07 -> 0xFBFD.
- Zero rule: seed=0xFFFF, 8 zero bytes, last=1 -> csum_data=0x0000 with ZERO_TO_FFFF=0; 0xFFFF with ZERO_TO_FFFF=1.
- Overrun: two single-beat packets 4 cycles apart, csum_ready=0 -> the first result is held, err_overrun=1 for 1 cycle. Then csum_ready=1 -> the first result is accepted and csum_valid=0.
- Reset mid-packet: areset for 1 cycle after beat 2 of 5, then the IPv4 header packet -> no result from the aborted packet; the next result is 0xB861.
